serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 127 ++++++++++++
 tb/tb_serial_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Parallel-to-serial transmitter: start bit, DATA_W data bits LSB first, even parity, stop bit.
// Each bit is held for CLKS_PER_BIT cycles; ser_out is registered and trails the FSM state by one cycle.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              ser_out,
    output logic              busy_out,
    output logic              done_out
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  tick_q, tick_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              parity_q, parity_d;
    logic              ser_q, ser_d;
    logic              done_q, done_d;
    logic              bit_end;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        done_d    = 1'b0;
        ser_d     = 1'b1;
        bit_end   = (tick_q == CNT_LAST);

        // The tick counter only runs while a frame is on the line.
        if (state_q != IDLE) begin
            tick_d = bit_end ? '0 : tick_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                tick_d    = '0;
                bit_idx_d = '0;
                if (valid_in) begin
                    state_d  = START;
                    shift_d  = data_in;
                    parity_d = even_parity(data_in);
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == IDX_LAST) begin
                        state_d   = PARITY;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_q)
            START:   ser_d = 1'b0;
            DATA:    ser_d = shift_q[0];
            PARITY:  ser_d = parity_q;
            default: ser_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            ser_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            ser_q     <= ser_d;
            done_q    <= done_d;
        end
    end

    assign ready_out = (state_q == IDLE) && !rst;
    assign busy_out  = (state_q != IDLE);
    assign ser_out   = ser_q;
    assign done_out  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: frame vectors with hand-computed bit sequences plus
// back-to-back, ignored-valid, mid-frame reset and single-cycle-bit sequences.
module tb_serial_tx;

    logic       clk;
    logic       rst;
    logic       sel;
    logic [7:0] data4, data1;
    logic       valid4, valid1;
    logic       ready4, ready1, ser4, ser1, busy4, busy1, done4, done1;
    logic       ser_m, busy_m, done_m, ready_m;

    int checks;
    int failures;

    typedef struct {
        logic [7:0]  data;
        logic [0:10] frame;
    } vec_t;

    vec_t vecs[6];

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .data_in(data4), .valid_in(valid4),
        .ready_out(ready4), .ser_out(ser4), .busy_out(busy4), .done_out(done4)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data1), .valid_in(valid1),
        .ready_out(ready1), .ser_out(ser1), .busy_out(busy1), .done_out(done1)
    );

    assign ser_m   = sel ? ser1   : ser4;
    assign busy_m  = sel ? busy1  : busy4;
    assign done_m  = sel ? done1  : done4;
    assign ready_m = sel ? ready1 : ready4;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic v);
        if (sel) begin
            data1  = d;
            valid1 = v;
        end else begin
            data4  = d;
            valid4 = v;
        end
    endtask

    // Called #1 after the acceptance edge; walks every cycle of the frame.
    task automatic check_frame(input logic [0:10] f, input int cpb, input int inj, input string nm);
        int len;
        len = 11 * cpb;
        for (int k = 1; k <= len; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s/ser c%0d", nm, k), ser_m, f[(k-1)/cpb]);
            chk($sformatf("%s/busy c%0d", nm, k), busy_m, (k < len));
            chk($sformatf("%s/done c%0d", nm, k), done_m, (k == len));
            chk($sformatf("%s/ready c%0d", nm, k), ready_m, (k == len));
            if (k == inj) drive(8'hFF, 1'b1);
            if (k == inj + 1) drive(8'h00, 1'b0);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [0:10] f, input int cpb, input int inj,
                        input string nm);
        @(negedge clk);
        drive(d, 1'b1);
        chk({nm, "/ready_pre"}, ready_m, 1'b1);
        @(posedge clk);
        #1;
        drive(~d, 1'b0);
        chk({nm, "/busy_acc"}, busy_m, 1'b1);
        chk({nm, "/ser_acc"}, ser_m, 1'b1);
        check_frame(f, cpb, inj, nm);
        @(posedge clk);
        #1;
        chk({nm, "/ser_after"}, ser_m, 1'b1);
        chk({nm, "/done_after"}, done_m, 1'b0);
        chk({nm, "/busy_after"}, busy_m, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sel      = 1'b0;
        data1    = 8'h00;
        valid1   = 1'b0;

        vecs[0] = '{8'hA5, 11'b01010010101};
        vecs[1] = '{8'h07, 11'b01110000011};
        vecs[2] = '{8'h55, 11'b01010101001};
        vecs[3] = '{8'h00, 11'b00000000001};
        vecs[4] = '{8'hFF, 11'b01111111101};
        vecs[5] = '{8'h80, 11'b00000000111};

        // Reset with a simultaneous valid: reset must win.
        rst    = 1'b1;
        data4  = 8'hAA;
        valid4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/ser4", ser4, 1'b1);
        chk("rst/busy4", busy4, 1'b0);
        chk("rst/done4", done4, 1'b0);
        chk("rst/ready4", ready4, 1'b0);
        chk("rst/ser1", ser1, 1'b1);
        chk("rst/busy1", busy1, 1'b0);
        chk("rst/ready1", ready1, 1'b0);
        valid4 = 1'b0;
        rst    = 1'b0;
        #1;
        chk("rst_rel/ready4", ready4, 1'b1);
        chk("rst_rel/ready1", ready1, 1'b1);

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].data, vecs[i].frame, 4, -1, $sformatf("vec%0d_%02h", i, vecs[i].data));
        end

        // Held valid: 0x3C then 0xC3 with a single idle cycle between frames.
        @(negedge clk);
        drive(8'h3C, 1'b1);
        @(posedge clk);
        #1;
        drive(8'hC3, 1'b1);
        check_frame(11'b00011110001, 4, -1, "b2b_3C");
        @(posedge clk);
        #1;
        drive(8'h00, 1'b0);
        chk("b2b/busy_acc2", busy_m, 1'b1);
        check_frame(11'b01100001101, 4, -1, "b2b_C3");
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b/idle_busy%0d", k), busy_m, 1'b0);
            chk($sformatf("b2b/idle_ser%0d", k), ser_m, 1'b1);
            chk($sformatf("b2b/idle_done%0d", k), done_m, 1'b0);
        end

        // A 0xFF pulse mid-frame is ignored and queues nothing.
        send(8'hA5, 11'b01010010101, 4, 10, "ignore");
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("ignore/no_frame_busy%0d", k), busy_m, 1'b0);
            chk($sformatf("ignore/no_frame_ser%0d", k), ser_m, 1'b1);
        end

        // Reset during DATA aborts the frame without a done pulse.
        @(negedge clk);
        drive(8'hA5, 1'b1);
        @(posedge clk);
        #1;
        drive(8'h00, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        chk("abort/busy_pre", busy_m, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort/ser", ser_m, 1'b1);
        chk("abort/busy", busy_m, 1'b0);
        chk("abort/done", done_m, 1'b0);
        chk("abort/ready_in_rst", ready_m, 1'b0);
        rst = 1'b0;
        #1;
        chk("abort/ready_rel", ready_m, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort/no_done%0d", k), done_m, 1'b0);
            chk($sformatf("abort/ser_idle%0d", k), ser_m, 1'b1);
        end
        send(8'h55, 11'b01010101001, 4, -1, "post_abort_55");

        // Single-cycle bits on the second instance.
        sel = 1'b1;
        send(8'h01, 11'b01000000011, 1, -1, "cpb1_01");
        sel = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
